mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register (upstream) and the MEM/WB register (downstream).
- Takes the registered EX/MEM control and data and performs the load or store on a data-memory port with a req/ack handshake.
- Stalls the pipeline while memory is busy. Produces the RegWrite, MemtoReg, ReadData, ALU result and destination-register fields that the MEM/WB register latches.
- Detects misaligned word accesses and memory-ack timeouts.

---
 rtl/mips_pipe_pkg.sv | 19 +
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_timeout_counter.sv | 30 +++
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage.
package mips_pipe_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack port between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    import mips_pipe_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter for a pending memory access; expired flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned       CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at LAST instead of wrapping so expired stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the dmem port, stalls upstream while busy, feeds MEM/WB.
module mem_access_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     write_data_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    mem_access_stage_if.master    dmem,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic                  wb_reg_write_out,
    output logic                  wb_mem_to_reg_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [REG_ADDR_W-1:0] write_reg_out,
    output logic                  misalign_err,
    output logic                  bus_err
);

    mem_state_e            r_state,      w_state_nxt;
    logic                  r_dmem_req,   w_dmem_req_nxt;
    logic                  r_dmem_we,    w_dmem_we_nxt;
    logic [ADDR_W-1:0]     r_dmem_addr,  w_dmem_addr_nxt;
    logic [DATA_W-1:0]     r_dmem_wdata, w_dmem_wdata_nxt;
    logic                  r_valid_out,  w_valid_nxt;
    wb_ctrl_t              r_wb_out,     w_wb_nxt;
    logic [DATA_W-1:0]     r_read_data,  w_read_data_nxt;
    logic [DATA_W-1:0]     r_alu_out,    w_alu_nxt;
    logic [REG_ADDR_W-1:0] r_wreg_out,   w_wreg_nxt;
    logic                  r_misalign,   w_misalign_nxt;
    logic                  r_bus_err,    w_bus_err_nxt;
    wb_ctrl_t              r_cap_wb,     w_cap_wb_nxt;
    logic                  r_cap_load,   w_cap_load_nxt;
    logic [DATA_W-1:0]     r_cap_alu,    w_cap_alu_nxt;
    logic [REG_ADDR_W-1:0] r_cap_wreg,   w_cap_wreg_nxt;

    logic w_mem_op;
    logic w_misaligned;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expired;

    assign w_mem_op     = mem_read_in | mem_write_in;
    assign w_misaligned = |(alu_result_in[1:0] & WORD_ALIGN_MASK);

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    // Gated by rst_n so upstream is released the instant reset hits.
    assign stall_out = rst_n & ((r_state == ACCESS) |
                                ((r_state == IDLE) & valid_in & w_mem_op & ~w_misaligned));

    always_comb begin
        w_state_nxt      = r_state;
        w_dmem_req_nxt   = r_dmem_req;
        w_dmem_we_nxt    = r_dmem_we;
        w_dmem_addr_nxt  = r_dmem_addr;
        w_dmem_wdata_nxt = r_dmem_wdata;
        w_valid_nxt      = 1'b0;
        w_wb_nxt         = r_wb_out;
        w_read_data_nxt  = r_read_data;
        w_alu_nxt        = r_alu_out;
        w_wreg_nxt       = r_wreg_out;
        w_misalign_nxt   = r_misalign;
        w_bus_err_nxt    = r_bus_err;
        w_cap_wb_nxt     = r_cap_wb;
        w_cap_load_nxt   = r_cap_load;
        w_cap_alu_nxt    = r_cap_alu;
        w_cap_wreg_nxt   = r_cap_wreg;
        w_cnt_clear      = 1'b0;
        w_cnt_en         = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (valid_in) begin
                    if (!w_mem_op || w_misaligned) begin
                        w_valid_nxt          = 1'b1;
                        w_wb_nxt.reg_write   = reg_write_in & ~w_mem_op;
                        w_wb_nxt.mem_to_reg  = mem_to_reg_in;
                        w_read_data_nxt      = '0;
                        w_alu_nxt            = alu_result_in;
                        w_wreg_nxt           = write_reg_in;
                        w_misalign_nxt       = r_misalign | w_mem_op;
                    end else begin
                        w_state_nxt              = ACCESS;
                        w_dmem_req_nxt           = 1'b1;
                        w_dmem_we_nxt            = mem_write_in;
                        w_dmem_addr_nxt          = ADDR_W'(alu_result_in);
                        w_dmem_wdata_nxt         = write_data_in;
                        w_cap_wb_nxt.reg_write   = reg_write_in;
                        w_cap_wb_nxt.mem_to_reg  = mem_to_reg_in;
                        w_cap_load_nxt           = ~mem_write_in;
                        w_cap_alu_nxt            = alu_result_in;
                        w_cap_wreg_nxt           = write_reg_in;
                        w_cnt_clear              = 1'b1;
                    end
                end
            end
            ACCESS: begin
                w_cnt_en = 1'b1;
                // An ack in the expiring cycle still completes the access normally.
                if (dmem.dmem_ack || w_expired) begin
                    w_state_nxt     = DONE;
                    w_dmem_req_nxt  = 1'b0;
                    w_dmem_we_nxt   = 1'b0;
                    w_valid_nxt     = 1'b1;
                    w_wb_nxt        = r_cap_wb;
                    w_alu_nxt       = r_cap_alu;
                    w_wreg_nxt      = r_cap_wreg;
                    w_read_data_nxt = (dmem.dmem_ack && r_cap_load) ? dmem.dmem_rdata : '0;
                    if (!dmem.dmem_ack) begin
                        w_wb_nxt.reg_write = 1'b0;
                        w_bus_err_nxt      = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_valid_out  <= 1'b0;
            r_wb_out     <= '0;
            r_read_data  <= '0;
            r_alu_out    <= '0;
            r_wreg_out   <= '0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
            r_cap_wb     <= '0;
            r_cap_load   <= 1'b0;
            r_cap_alu    <= '0;
            r_cap_wreg   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_dmem_req   <= w_dmem_req_nxt;
            r_dmem_we    <= w_dmem_we_nxt;
            r_dmem_addr  <= w_dmem_addr_nxt;
            r_dmem_wdata <= w_dmem_wdata_nxt;
            r_valid_out  <= w_valid_nxt;
            r_wb_out     <= w_wb_nxt;
            r_read_data  <= w_read_data_nxt;
            r_alu_out    <= w_alu_nxt;
            r_wreg_out   <= w_wreg_nxt;
            r_misalign   <= w_misalign_nxt;
            r_bus_err    <= w_bus_err_nxt;
            r_cap_wb     <= w_cap_wb_nxt;
            r_cap_load   <= w_cap_load_nxt;
            r_cap_alu    <= w_cap_alu_nxt;
            r_cap_wreg   <= w_cap_wreg_nxt;
        end
    end

    assign dmem.dmem_req   = r_dmem_req;
    assign dmem.dmem_we    = r_dmem_we;
    assign dmem.dmem_addr  = r_dmem_addr;
    assign dmem.dmem_wdata = r_dmem_wdata;

    assign valid_out         = r_valid_out;
    assign wb_reg_write_out  = r_wb_out.reg_write;
    assign wb_mem_to_reg_out = r_wb_out.mem_to_reg;
    assign read_data_out     = r_read_data;
    assign alu_result_out    = r_alu_out;
    assign write_reg_out     = r_wreg_out;
    assign misalign_err      = r_misalign;
    assign bus_err           = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expectations, a monitor checks each valid_out.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [4:0]  write_reg_in;
    logic        stall_out;
    logic        valid_out;
    logic        wb_reg_write_out;
    logic        wb_mem_to_reg_out;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  write_reg_out;
    logic        misalign_err;
    logic        bus_err;

    mem_access_stage_if #(.ADDR_W(32)) dif ();

    mem_access_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_in          (valid_in),
        .mem_read_in       (mem_read_in),
        .mem_write_in      (mem_write_in),
        .reg_write_in      (reg_write_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .alu_result_in     (alu_result_in),
        .write_data_in     (write_data_in),
        .write_reg_in      (write_reg_in),
        .dmem              (dif),
        .stall_out         (stall_out),
        .valid_out         (valid_out),
        .wb_reg_write_out  (wb_reg_write_out),
        .wb_mem_to_reg_out (wb_mem_to_reg_out),
        .read_data_out     (read_data_out),
        .alu_result_out    (alu_result_out),
        .write_reg_out     (write_reg_out),
        .misalign_err      (misalign_err),
        .bus_err           (bus_err)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push(logic rw, logic m2r, logic [31:0] rdata, logic [31:0] alu, logic [4:0] wreg);
        exp_t e;
        e.rw = rw; e.m2r = m2r; e.rdata = rdata; e.alu = alu; e.wreg = wreg;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic rd, logic wr, logic rw, logic m2r, logic [31:0] alu, logic [31:0] wd, logic [4:0] wreg);
        valid_in      = 1'b1;
        mem_read_in   = rd;
        mem_write_in  = wr;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
        alu_result_in = alu;
        write_data_in = wd;
        write_reg_in  = wreg;
    endtask

    task automatic idle_in();
        valid_in      = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        reg_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        alu_result_in = '0;
        write_data_in = '0;
        write_reg_in  = '0;
    endtask

    // Inputs already driven; acks the request in its ack_after-th cycle (0 = never).
    task automatic mem_op(string name, int ack_after, logic [31:0] rdata, logic [31:0] exp_addr,
                          logic exp_we, logic [31:0] exp_wdata, int exp_req, int exp_stall);
        int  req_cyc;
        int  stall_cyc;
        bit  done;
        req_cyc = 0; stall_cyc = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (stall_out) stall_cyc++;
            if (dif.dmem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    check({name, "_addr"}, dif.dmem_addr, exp_addr);
                    check({name, "_we"}, 32'(dif.dmem_we), 32'(exp_we));
                    check({name, "_wdata"}, dif.dmem_wdata, exp_wdata);
                end
                if (req_cyc == ack_after) begin
                    dif.dmem_ack   = 1'b1;
                    dif.dmem_rdata = rdata;
                end
            end
            tick();
            dif.dmem_ack   = 1'b0;
            dif.dmem_rdata = '0;
            if (valid_out) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_complete: valid_out never rose within 20 cycles", name);
        end
        idle_in();
        check({name, "_req_cycles"}, 32'(req_cyc), 32'(exp_req));
        check({name, "_stall_cycles"}, 32'(stall_cyc), 32'(exp_stall));
        @(negedge clk);
        check({name, "_stall_done"}, 32'(stall_out), 32'd0);
        tick();
    endtask

    // Monitor: every valid_out cycle must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got valid_out=1 expected no output (alu=%h)", alu_result_out);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_reg_write", 32'(wb_reg_write_out), 32'(e.rw));
                    check("sb_mem_to_reg", 32'(wb_mem_to_reg_out), 32'(e.m2r));
                    check("sb_read_data", read_data_out, e.rdata);
                    check("sb_alu_result", alu_result_out, e.alu);
                    check("sb_write_reg", 32'(write_reg_out), 32'(e.wreg));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = '0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dif.dmem_req), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        check("rst_alu", alu_result_out, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Pass-through: one-cycle latency, no stall, outputs hold afterwards.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        push(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
        #1 check("pt_stall", 32'(stall_out), 32'd0);
        tick();
        idle_in();
        repeat (2) tick();
        check("pt_hold_alu", alu_result_out, 32'h0000_1234);
        check("pt_hold_valid", 32'(valid_out), 32'd0);

        // Load, ack in third request cycle.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
        push(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd7);
        mem_op("load", 3, 32'hDEAD_BEEF, 32'h100, 1'b1 ^ 1'b1, 32'h0, 3, 4);

        // Store, ack after one cycle; returned rdata must be ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFE_F00D, 5'd0);
        push(1'b0, 1'b0, 32'h0, 32'h200, 5'd0);
        mem_op("store", 1, 32'h1234_5678, 32'h200, 1'b1, 32'hCAFE_F00D, 1, 2);

        // Read and write both set behaves as a store.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 32'h5555_AAAA, 5'd2);
        push(1'b0, 1'b0, 32'h0, 32'h204, 5'd2);
        mem_op("rdwr", 2, 32'h7777_7777, 32'h204, 1'b1, 32'h5555_AAAA, 2, 3);

        // Ack in the final (timeout) cycle completes normally.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h180, 32'h0, 5'd9);
        push(1'b1, 1'b1, 32'h0102_0304, 32'h180, 5'd9);
        mem_op("late_ack", 4, 32'h0102_0304, 32'h180, 1'b0, 32'h0, 4, 5);
        check("late_ack_bus_err", 32'(bus_err), 32'd0);

        // Misaligned load: no request, error flag, reg write suppressed.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd11);
        push(1'b0, 1'b1, 32'h0, 32'h103, 5'd11);
        #1 check("mis_stall", 32'(stall_out), 32'd0);
        tick();
        idle_in();
        check("mis_req", 32'(dif.dmem_req), 32'd0);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_bus_err", 32'(bus_err), 32'd0);
        tick();

        // Timeout: never acked.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd3);
        push(1'b0, 1'b1, 32'h0, 32'h300, 5'd3);
        mem_op("timeout", 0, 32'h0, 32'h300, 1'b0, 32'h0, 4, 5);
        check("timeout_bus_err", 32'(bus_err), 32'd1);
        check("timeout_mis_sticky", 32'(misalign_err), 32'd1);

        // Reset two cycles into an access abandons it.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd4);
        tick();
        check("rstacc_req_up", 32'(dif.dmem_req), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstacc_req", 32'(dif.dmem_req), 32'd0);
        check("rstacc_stall", 32'(stall_out), 32'd0);
        check("rstacc_valid", 32'(valid_out), 32'd0);
        check("rstacc_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        idle_in();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Load after reset completes normally.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd12);
        push(1'b1, 1'b1, 32'h0BAD_F00D, 32'h104, 5'd12);
        mem_op("post_rst", 2, 32'h0BAD_F00D, 32'h104, 1'b0, 32'h0, 2, 3);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
